// File: rtl/registrador_serializador_if.sv
// Word-source side of the serializer: load strobe, parallel word,
// serial line and handshake flags.
interface registrador_serializador_if #(
  parameter int WIDTH = 4
);
  logic             carga;
  logic [WIDTH-1:0] dado;
  logic             saida;
  logic             valido;
  logic             pronto;
  logic             ocupado;
  logic             fim;

  modport master (
    output carga, dado,
    input  saida, valido, pronto, ocupado, fim
  );

  modport slave (
    input  carga, dado,
    output saida, valido, pronto, ocupado, fim
  );
endinterface

// File: rtl/registrador_serializador.sv
// Parallel-in/serial-out transmitter: shifts a WIDTH-bit word out LSB first,
// optionally followed by an even-parity bit, with registered handshake flags.
module registrador_serializador #(
  parameter int WIDTH    = 4,
  parameter int PARIDADE = 0
) (
  input logic                       clock,
  input logic                       reset,
  registrador_serializador_if.slave bus
);

  localparam int N     = WIDTH + PARIDADE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENVIA = 2'd1,
    FIM   = 2'd2
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [N-1:0]     sr_q, sr_d;
  logic [N-1:0]     palavra;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             saida_q, saida_d;
  logic             valido_q, valido_d;
  logic             pronto_q, pronto_d;
  logic             ocupado_q, ocupado_d;
  logic             fim_q, fim_d;

  // Full frame as it goes on the wire: data bits, then parity in the top slot.
  always_comb begin
    palavra = N'(bus.dado);
    if (PARIDADE != 0) palavra[N-1] = ^bus.dado;
  end

  // sr_q holds the bits still to be sent after the one currently on saida_q.
  always_comb begin
    estado_d  = IDLE;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    saida_d   = 1'b0;
    valido_d  = 1'b0;
    pronto_d  = 1'b1;
    ocupado_d = 1'b0;
    fim_d     = 1'b0;
    case (estado_q)
      IDLE: begin
        if (bus.carga) begin
          estado_d  = ENVIA;
          saida_d   = palavra[0];
          sr_d      = palavra >> 1;
          cnt_d     = '0;
          valido_d  = 1'b1;
          ocupado_d = 1'b1;
          pronto_d  = 1'b0;
        end
      end
      ENVIA: begin
        pronto_d = 1'b0;
        if (cnt_q == CNT_W'(N - 1)) begin
          estado_d = FIM;
          fim_d    = 1'b1;
        end else begin
          estado_d  = ENVIA;
          saida_d   = sr_q[0];
          sr_d      = sr_q >> 1;
          cnt_d     = cnt_q + 1'b1;
          valido_d  = 1'b1;
          ocupado_d = 1'b1;
        end
      end
      FIM: begin
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
        sr_d     = '0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      saida_q   <= 1'b0;
      valido_q  <= 1'b0;
      pronto_q  <= 1'b1;
      ocupado_q <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      saida_q   <= saida_d;
      valido_q  <= valido_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
      fim_q     <= fim_d;
    end
  end

  assign bus.saida   = saida_q;
  assign bus.valido  = valido_q;
  assign bus.pronto  = pronto_q;
  assign bus.ocupado = ocupado_q;
  assign bus.fim     = fim_q;

endmodule

// File: tb/tb_registrador_serializador.sv
// Bench for registrador_serializador: one instance without parity, one with;
// expected serial bits are queued by the stimulus and popped by monitors.
module tb_registrador_serializador;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic q0[$];
  logic q1[$];

  always #5 clock = ~clock;

  registrador_serializador_if #(.WIDTH(4)) b0 ();
  registrador_serializador_if #(.WIDTH(4)) b1 ();

  registrador_serializador #(.WIDTH(4), .PARIDADE(0)) dut0 (
    .clock(clock), .reset(reset), .bus(b0.slave)
  );
  registrador_serializador #(.WIDTH(4), .PARIDADE(1)) dut1 (
    .clock(clock), .reset(reset), .bus(b1.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: each valid serial bit must match the head of its queue.
  always @(negedge clock) begin
    if (reset && b0.valido) begin
      n_chk++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL d0_unexpected_bit: got saida=%0b expected no valid bit at %0t", b0.saida, $time);
      end else begin
        logic e0;
        e0 = q0.pop_front();
        if (b0.saida !== e0) begin
          n_fail++;
          $display("FAIL d0_bit: got %0b expected %0b at %0t", b0.saida, e0, $time);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset && b1.valido) begin
      n_chk++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL d1_unexpected_bit: got saida=%0b expected no valid bit at %0t", b1.saida, $time);
      end else begin
        logic e1;
        e1 = q1.pop_front();
        if (b1.saida !== e1) begin
          n_fail++;
          $display("FAIL d1_bit: got %0b expected %0b at %0t", b1.saida, e1, $time);
        end
      end
    end
  end

  task automatic drive(input int sel, input logic c, input logic [3:0] d);
    if (sel != 0) begin b1.carga = c; b1.dado = d; end
    else          begin b0.carga = c; b0.dado = d; end
  endtask

  // One word: stream holds the expected wire bits (LSB first), n of them.
  // spur > 0 pulses carga with dado=0 so it is sampled at edge k+spur.
  task automatic send(input int sel, input logic [3:0] d, input logic [4:0] stream,
                      input int n, input int spur);
    logic f, v, p, o;
    for (int i = 0; i < n; i++) begin
      if (sel != 0) q1.push_back(stream[i]);
      else          q0.push_back(stream[i]);
    end
    @(posedge clock); #1 drive(sel, 1'b1, d);
    @(posedge clock); #1 drive(sel, 1'b0, d);
    for (int c = 1; c <= n + 3; c++) begin
      if (c == spur) drive(sel, 1'b1, 4'b0000);
      else if (c > 1) drive(sel, 1'b0, 4'b0000);
      @(negedge clock);
      f = (sel != 0) ? b1.fim     : b0.fim;
      v = (sel != 0) ? b1.valido  : b0.valido;
      p = (sel != 0) ? b1.pronto  : b0.pronto;
      o = (sel != 0) ? b1.ocupado : b0.ocupado;
      chk($sformatf("s%0d_fim_c%0d", sel, c),     32'(f), 32'(c == n + 1));
      chk($sformatf("s%0d_valido_c%0d", sel, c),  32'(v), 32'(c <= n));
      chk($sformatf("s%0d_pronto_c%0d", sel, c),  32'(p), 32'(c >= n + 2));
      chk($sformatf("s%0d_ocupado_c%0d", sel, c), 32'(o), 32'(c <= n));
      @(posedge clock); #1;
    end
    drive(sel, 1'b0, 4'b0000);
    chk($sformatf("s%0d_queue_empty", sel), 32'((sel != 0) ? q1.size() : q0.size()), 32'd0);
  endtask

  initial begin
    int first, last, vcnt, fcnt;
    drive(0, 1'b0, 4'b0000);
    drive(1, 1'b0, 4'b0000);

    // Reset values while held in reset
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_saida", 32'(b0.saida), 32'd0);
    chk("rst_valido", 32'(b0.valido), 32'd0);
    chk("rst_ocupado", 32'(b0.ocupado), 32'd0);
    chk("rst_fim", 32'(b0.fim), 32'd0);
    chk("rst_pronto", 32'(b0.pronto), 32'd1);
    reset = 1'b1;

    // Basic word 1011 -> 1,1,0,1
    send(0, 4'b1011, 5'b01011, 4, 0);
    // Ignored load at k+2
    send(0, 4'b1011, 5'b01011, 4, 2);

    // Back-to-back: 0001 then 1000 with carga held
    q0.push_back(1'b1); q0.push_back(1'b0); q0.push_back(1'b0); q0.push_back(1'b0);
    q0.push_back(1'b0); q0.push_back(1'b0); q0.push_back(1'b0); q0.push_back(1'b1);
    first = 0; last = 0; vcnt = 0; fcnt = 0;
    @(posedge clock); #1 drive(0, 1'b1, 4'b0001);
    @(posedge clock); #1 drive(0, 1'b1, 4'b1000);
    for (int c = 1; c <= 12; c++) begin
      if (c == 7) drive(0, 1'b0, 4'b0000);
      @(negedge clock);
      if (b0.valido) begin
        if (first == 0) first = c;
        last = c;
        vcnt++;
      end
      if (b0.fim) fcnt++;
      @(posedge clock); #1;
    end
    chk("b2b_first", 32'(first), 32'd1);
    chk("b2b_valid_count", 32'(vcnt), 32'd8);
    chk("b2b_gap", 32'(last - first + 1 - vcnt), 32'd2);
    chk("b2b_fim_count", 32'(fcnt), 32'd2);
    chk("b2b_queue_empty", 32'(q0.size()), 32'd0);

    // Reset mid-word: only the first two bits of 1111 go out
    q0.push_back(1'b1); q0.push_back(1'b1);
    @(posedge clock); #1 drive(0, 1'b1, 4'b1111);
    @(posedge clock); #1 drive(0, 1'b0, 4'b0000);
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    chk("midrst_saida", 32'(b0.saida), 32'd0);
    chk("midrst_valido", 32'(b0.valido), 32'd0);
    chk("midrst_pronto", 32'(b0.pronto), 32'd1);
    chk("midrst_ocupado", 32'(b0.ocupado), 32'd0);
    chk("midrst_queue_empty", 32'(q0.size()), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    send(0, 4'b0101, 5'b00101, 4, 0);

    // Parity: 0111 -> 1,1,1,0,p=1 ; 0011 -> 1,1,0,0,p=0
    send(1, 4'b0111, 5'b10111, 5, 0);
    send(1, 4'b0011, 5'b00011, 5, 0);

    repeat (2) @(posedge clock);
    chk("final_q0_empty", 32'(q0.size()), 32'd0);
    chk("final_q1_empty", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
